// File: rtl/spi_master_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spi_pkg
// Purpose  : Shared types and frame-layout constants for the register-access
//            SPI master (state encoding, frame field positions and widths).
// Revision : 1.0  initial release
// ============================================================================
package spi_pkg;

  // Controller states; the top module mirrors these as fixed-width constants.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_HIGH  = 3'd2,
    ST_LOW   = 3'd3,
    ST_HOLD  = 3'd4,
    ST_GAP   = 3'd5
  } spi_state_e;

  // Frame layout: {rw, addr[6:0], data[7:0]}, transmitted MSB first.
  localparam int FRAME_BITS = 16;
  localparam int RW_BIT     = 15;
  localparam int ADDR_LSB   = 8;
  localparam int ADDR_BITS  = 7;
  localparam int DATA_BITS  = 8;

endpackage
`default_nettype wire

// File: rtl/spi_master_if.sv
`default_nettype none
// ============================================================================
// Module   : spi_master_if
// Purpose  : Command/response bus between host command logic and spi_master.
// Signals  : cmd_valid/cmd_ready handshake, cmd_read, cmd_addr, cmd_wdata,
//            rsp_valid pulse with rsp_rdata, busy status.
// Modports : master - host side (issues commands)
//            slave  - spi_master side (accepts commands, returns responses)
// Revision : 1.0  initial release
// ============================================================================
interface spi_master_if;
  import spi_pkg::*;

  logic                 cmd_valid;
  logic                 cmd_ready;
  logic                 cmd_read;
  logic [ADDR_BITS-1:0] cmd_addr;
  logic [DATA_BITS-1:0] cmd_wdata;
  logic                 rsp_valid;
  logic [DATA_BITS-1:0] rsp_rdata;
  logic                 busy;

  modport master (
    output cmd_valid, cmd_read, cmd_addr, cmd_wdata,
    input  cmd_ready, rsp_valid, rsp_rdata, busy
  );

  modport slave (
    input  cmd_valid, cmd_read, cmd_addr, cmd_wdata,
    output cmd_ready, rsp_valid, rsp_rdata, busy
  );

endinterface
`default_nettype wire

// File: rtl/spi_master_miso_sync.sv
`default_nettype none
// ============================================================================
// Module   : spi_miso_sync
// Purpose  : Two-flop synchronizer for the miso input.
// Ports    : clk, reset (sync, active-high), d (async in), q (synchronized out)
// Revision : 1.0  initial release
// ============================================================================
module spi_miso_sync (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= d;
      r_sync <= r_meta;
    end
  end

  assign q = r_sync;

endmodule
`default_nettype wire

// File: rtl/spi_master.sv
`default_nettype none
// ============================================================================
// Module   : spi_master
// Purpose  : Register-access SPI master. Accepts one read/write command,
//            shifts a 16-bit {rw, addr, data} frame out on sck/ss/mosi and
//            returns the data byte captured from miso on rises 9..16.
// Ports    : clk, reset (sync, active-high)
//            bus  - spi_master_if.slave command/response bus
//            sck  - SPI clock, idles low
//            ss   - slave select, active-low
//            mosi - serial out, MSB first
//            miso - serial in
// Params   : CLK_DIV    - sck half-period in clk cycles (1..255)
//            GAP_CYCLES - ss-high cycles between frames (2..255)
// Macro    : SPI_MASTER_MISO_SYNC_EN - route miso through a 2-flop
//            synchronizer before capture (requires CLK_DIV >= 3)
// Revision : 1.0  initial release
// ============================================================================
module spi_master
  import spi_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter int GAP_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  spi_master_if.slave bus,
  output logic        sck,
  output logic        ss,
  output logic        mosi,
  input  logic        miso
);

  localparam logic [2:0] S_IDLE  = ST_IDLE;
  localparam logic [2:0] S_SETUP = ST_SETUP;
  localparam logic [2:0] S_HIGH  = ST_HIGH;
  localparam logic [2:0] S_LOW   = ST_LOW;
  localparam logic [2:0] S_HOLD  = ST_HOLD;
  localparam logic [2:0] S_GAP   = ST_GAP;

  localparam logic [7:0] DIV_LOAD   = 8'(CLK_DIV - 1);
  localparam logic [7:0] GAP_LOAD   = 8'(GAP_CYCLES - 1);
  localparam logic [4:0] RISES_LAST = 5'(FRAME_BITS);
  localparam logic [4:0] RISE_RX0   = 5'(ADDR_LSB);

  logic [2:0]            r_state;
  logic [7:0]            r_div;       // phase counter, reused for the gap
  logic [4:0]            r_rise;      // sck rises completed in this frame
  logic [FRAME_BITS-1:0] r_tx;
  logic [DATA_BITS-1:0]  r_rx;
  logic                  r_is_read;
  logic                  r_cmd_ready;
  logic                  r_rsp_valid;
  logic [DATA_BITS-1:0]  r_rsp_rdata;
  logic                  r_sck;
  logic                  r_ss;
  logic                  r_mosi;
  logic                  w_miso;
  logic                  w_div_done;

`ifdef SPI_MASTER_MISO_SYNC_EN
  spi_miso_sync u_miso_sync (
    .clk   (clk),
    .reset (reset),
    .d     (miso),
    .q     (w_miso)
  );
`else
  assign w_miso = miso;
`endif

  assign w_div_done = (r_div == 8'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_div       <= 8'd0;
      r_rise      <= 5'd0;
      r_tx        <= '0;
      r_rx        <= '0;
      r_is_read   <= 1'b0;
      r_cmd_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_sck       <= 1'b0;
      r_ss        <= 1'b1;
      r_mosi      <= 1'b0;
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.cmd_valid) begin
            r_tx        <= {bus.cmd_read, bus.cmd_addr,
                            bus.cmd_read ? {DATA_BITS{1'b0}} : bus.cmd_wdata};
            r_is_read   <= bus.cmd_read;
            r_mosi      <= bus.cmd_read;  // frame bit RW_BIT
            r_ss        <= 1'b0;
            r_cmd_ready <= 1'b0;
            r_div       <= DIV_LOAD;
            r_rise      <= 5'd0;
            r_state     <= S_SETUP;
          end
        end
        // SETUP and LOW both end in a rising edge of sck; the clk edge that
        // raises sck is also the miso capture point for the data half.
        S_SETUP, S_LOW: begin
          if (w_div_done) begin
            r_sck   <= 1'b1;
            r_div   <= DIV_LOAD;
            r_rise  <= r_rise + 5'd1;
            if (r_rise >= RISE_RX0) begin
              r_rx <= {r_rx[DATA_BITS-2:0], w_miso};
            end
            r_state <= S_HIGH;
          end else begin
            r_div <= r_div - 8'd1;
          end
        end
        S_HIGH: begin
          if (w_div_done) begin
            r_sck <= 1'b0;
            r_div <= DIV_LOAD;
            if (r_rise == RISES_LAST) begin
              // mosi keeps the last data bit through HOLD
              r_state <= S_HOLD;
            end else begin
              r_mosi  <= r_tx[RW_BIT-1];
              r_tx    <= r_tx << 1;
              r_state <= S_LOW;
            end
          end else begin
            r_div <= r_div - 8'd1;
          end
        end
        S_HOLD: begin
          if (w_div_done) begin
            r_ss        <= 1'b1;
            r_mosi      <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= r_is_read ? r_rx : {DATA_BITS{1'b0}};
            r_div       <= GAP_LOAD;
            r_state     <= S_GAP;
          end else begin
            r_div <= r_div - 8'd1;
          end
        end
        S_GAP: begin
          if (w_div_done) begin
            r_cmd_ready <= 1'b1;
            r_state     <= S_IDLE;
          end else begin
            r_div <= r_div - 8'd1;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.cmd_ready = r_cmd_ready;
  assign bus.busy      = ~r_cmd_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_rdata = r_rsp_rdata;
  assign sck           = r_sck;
  assign ss            = r_ss;
  assign mosi          = r_mosi;

endmodule
`default_nettype wire

// File: tb/tb_spi_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_master
// Purpose  : Self-checking bench for spi_master. A behavioural SPI slave
//            (register file) answers on miso; a reference memory predicts
//            read data and the exact frame word; latencies are derived from
//            the sck half-period arithmetic (1+33T, +gap).
// Revision : 1.0  initial release
// ============================================================================
module tb_spi_master;
  import spi_pkg::*;

  localparam int T    = 4;
  localparam int GAP  = 4;
`ifdef SPI_MASTER_MISO_SYNC_EN
  localparam int FT   = 3;
`else
  localparam int FT   = 1;
`endif
  localparam int FGAP = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  spi_master_if bus ();
  spi_master_if fbus ();
  logic sck, ss, mosi, miso;
  logic f_sck, f_ss, f_mosi, f_miso;

  spi_master #(.CLK_DIV(T), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .sck(sck), .ss(ss), .mosi(mosi), .miso(miso)
  );

  spi_master #(.CLK_DIV(FT), .GAP_CYCLES(FGAP)) dut_fast (
    .clk(clk), .reset(reset), .bus(fbus),
    .sck(f_sck), .ss(f_ss), .mosi(f_mosi), .miso(f_miso)
  );

  // ---------------- behavioural slave devices (shared register file) -------
  logic [7:0]  dev_mem [128];
  logic [7:0]  ref_mem [128];

  logic [15:0] s_rx = '0, s_word = '0;
  logic [7:0]  s_hdr = '0;
  int          s_cnt = 0, s_frames = 0;

  always @(posedge sck or negedge ss) begin
    if (!ss && sck) begin
      s_rx  <= {s_rx[14:0], mosi};
      s_cnt <= s_cnt + 1;
    end else if (!ss) begin
      s_rx  <= '0;
      s_cnt <= 0;
    end
  end

  // Read data goes out on the falls after the 8 header bits; on writes the
  // slave drives ones so the master has to zero rsp_rdata itself.
  always @(negedge sck or posedge ss) begin
    if (ss) begin
      miso <= 1'b0;
      if (s_cnt == 16) begin
        s_frames <= s_frames + 1;
        s_word   <= s_rx;
        if (!s_rx[15]) dev_mem[s_rx[14:8]] <= s_rx[7:0];
      end
    end else if (s_cnt == 8) begin
      s_hdr <= s_rx[7:0];
      miso  <= s_rx[7] ? dev_mem[s_rx[6:0]][7] : 1'b1;
    end else if (s_cnt > 8 && s_cnt < 16) begin
      miso  <= s_hdr[7] ? dev_mem[s_hdr[6:0]][15 - s_cnt] : 1'b1;
    end
  end

  logic [15:0] f_rx = '0, f_word = '0;
  logic [7:0]  f_hdr = '0;
  int          f_cnt = 0;

  always @(posedge f_sck or negedge f_ss) begin
    if (!f_ss && f_sck) begin
      f_rx  <= {f_rx[14:0], f_mosi};
      f_cnt <= f_cnt + 1;
    end else if (!f_ss) begin
      f_rx  <= '0;
      f_cnt <= 0;
    end
  end

  always @(negedge f_sck or posedge f_ss) begin
    if (f_ss) begin
      f_miso <= 1'b0;
      if (f_cnt == 16) f_word <= f_rx;
    end else if (f_cnt == 8) begin
      f_hdr  <= f_rx[7:0];
      f_miso <= f_rx[7] ? dev_mem[f_rx[6:0]][7] : 1'b1;
    end else if (f_cnt > 8 && f_cnt < 16) begin
      f_miso <= f_hdr[7] ? dev_mem[f_hdr[6:0]][15 - f_cnt] : 1'b1;
    end
  end

  // ---------------- checking helpers --------------------------------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!bus.cmd_ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("wait_ready", 32'(bus.cmd_ready), 32'd1);
  endtask

  // One complete command on the main DUT. If pulse_at > 0, a stray command
  // is pulsed that many cycles into the frame (must be ignored).
  task automatic run_txn(input logic rd, input logic [6:0] addr, input logic [7:0] wd,
                         input logic [7:0] exp_rd, input int pulse_at);
    int acc;
    int n;
    logic [15:0] exp_word;
    exp_word = {rd, addr, rd ? 8'h00 : wd};
    wait_ready();
    bus.cmd_valid = 1'b1;
    bus.cmd_read  = rd;
    bus.cmd_addr  = addr;
    bus.cmd_wdata = wd;
    acc = cyc;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    check($sformatf("ss_low@%02h", addr), 32'(ss), 32'd0);
    check($sformatf("busy@%02h", addr), 32'(bus.busy), 32'd1);
    check($sformatf("mosi_first@%02h", addr), 32'(mosi), 32'(rd));
    n = 1;
    while (!bus.rsp_valid && n < 400) begin
      @(negedge clk);
      n++;
      if (pulse_at > 0 && n == pulse_at) begin
        bus.cmd_valid = 1'b1;
        bus.cmd_read  = 1'b0;
        bus.cmd_addr  = addr ^ 7'h01;
        bus.cmd_wdata = ~wd;
      end else if (pulse_at > 0 && n == pulse_at + 1) begin
        bus.cmd_valid = 1'b0;
      end
    end
    check($sformatf("rsp_cycle@%02h", addr), 32'(cyc - acc), 32'(1 + 33 * T));
    check($sformatf("rsp_rdata@%02h", addr), 32'(bus.rsp_rdata), 32'(exp_rd));
    check($sformatf("ss_high_at_rsp@%02h", addr), 32'(ss), 32'd1);
    check($sformatf("mosi_idle@%02h", addr), 32'(mosi), 32'd0);
    check($sformatf("frame_word@%02h", addr), 32'(s_word), 32'(exp_word));
    @(negedge clk);
    check($sformatf("rsp_pulse@%02h", addr), 32'(bus.rsp_valid), 32'd0);
    check($sformatf("rdata_hold@%02h", addr), 32'(bus.rsp_rdata), 32'(exp_rd));
    while (!bus.cmd_ready && n < 800) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("ready_cycle@%02h", addr), 32'(cyc - acc), 32'(1 + 33 * T + GAP));
  endtask

  typedef struct {
    logic       rd;
    logic [6:0] addr;
    logic [7:0] wd;
    logic [7:0] exp_rd;
  } vec_t;

  vec_t vecs [5];

  initial begin
    int acc, n, hi, rises, frames0;
    logic prev;
    logic rd;
    logic [6:0] addr;
    logic [7:0] wd, exp_rd;

    for (int i = 0; i < 128; i++) begin
      dev_mem[i] = 8'h00;
      ref_mem[i] = 8'h00;
    end
    bus.cmd_valid = 1'b0; bus.cmd_read = 1'b0; bus.cmd_addr = '0; bus.cmd_wdata = '0;
    fbus.cmd_valid = 1'b0; fbus.cmd_read = 1'b0; fbus.cmd_addr = '0; fbus.cmd_wdata = '0;

    vecs[0] = '{1'b0, 7'h12, 8'hA5, 8'h00};
    vecs[1] = '{1'b1, 7'h12, 8'h00, 8'hA5};
    vecs[2] = '{1'b0, 7'h7F, 8'hFF, 8'h00};
    vecs[3] = '{1'b1, 7'h05, 8'h00, 8'h00};
    vecs[4] = '{1'b1, 7'h7F, 8'h5A, 8'hFF};

    // ---- reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rsp_rdata", 32'(bus.rsp_rdata), 32'd0);
    check("rst_sck", 32'(sck), 32'd0);
    check("rst_ss", 32'(ss), 32'd1);
    check("rst_mosi", 32'(mosi), 32'd0);
    reset = 1'b0;

    // ---- table-driven transactions
    for (int i = 0; i < 5; i++) begin
      run_txn(vecs[i].rd, vecs[i].addr, vecs[i].wd, vecs[i].exp_rd, 0);
      if (!vecs[i].rd) ref_mem[vecs[i].addr] = vecs[i].wd;
    end
    check("slave_reg_12", 32'(dev_mem[7'h12]), 32'h0000_00A5);

    // ---- fast instance: read 0x7F through minimum legal divider
    @(negedge clk);
    fbus.cmd_valid = 1'b1; fbus.cmd_read = 1'b1; fbus.cmd_addr = 7'h7F; fbus.cmd_wdata = 8'h00;
    acc = cyc;
    @(negedge clk);
    fbus.cmd_valid = 1'b0;
    n = 0;
    while (!fbus.rsp_valid && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("fast_rsp_cycle", 32'(cyc - acc), 32'(1 + 33 * FT));
    check("fast_rdata", 32'(fbus.rsp_rdata), 32'h0000_00FF);
    check("fast_word", 32'(f_word), 32'h0000_FF00);

    // ---- cmd_valid held across two writes: second accepted when ready returns
    wait_ready();
    bus.cmd_valid = 1'b1; bus.cmd_read = 1'b0; bus.cmd_addr = 7'h20; bus.cmd_wdata = 8'h11;
    acc = cyc;
    @(negedge clk);
    bus.cmd_addr = 7'h21; bus.cmd_wdata = 8'h22;
    n = 0; hi = 0;
    while (n < 400) begin
      @(negedge clk);
      n++;
      if (ss) hi++;
      if (bus.rsp_valid) check("b2b_word1", 32'(s_word), 32'h0000_2011);
      if (bus.cmd_ready) break;
    end
    check("b2b_ready_cycle", 32'(cyc - acc), 32'(1 + 33 * T + GAP));
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    check("b2b_second_accepted", 32'(bus.cmd_ready), 32'd0);
    check("b2b_ss_low", 32'(ss), 32'd0);
    // ss high from the response cycle through the re-accept cycle
    check("b2b_ss_high_cycles", 32'(hi), 32'(GAP + 1));
    acc = acc + 1 + 33 * T + GAP;
    n = 0;
    while (!bus.rsp_valid && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("b2b_rsp2_cycle", 32'(cyc - acc), 32'(1 + 33 * T));
    check("b2b_word2", 32'(s_word), 32'h0000_2122);
    ref_mem[7'h20] = 8'h11;
    ref_mem[7'h21] = 8'h22;

    // ---- stray command during busy is dropped
    frames0 = s_frames;
    run_txn(1'b0, 7'h30, 8'h5A, 8'h00, 60);
    ref_mem[7'h30] = 8'h5A;
    repeat (60) @(negedge clk);
    check("stray_frames", 32'(s_frames), 32'(frames0 + 1));
    check("stray_ss_idle", 32'(ss), 32'd1);
    check("stray_reg", 32'(dev_mem[7'h31]), 32'(ref_mem[7'h31]));

    // ---- reset asserted at rise 5 of a frame
    run_txn(1'b1, 7'h12, 8'h00, ref_mem[7'h12], 0);
    wait_ready();
    frames0 = s_frames;
    bus.cmd_valid = 1'b1; bus.cmd_read = 1'b0; bus.cmd_addr = 7'h40; bus.cmd_wdata = 8'h99;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    n = 0; rises = 0; prev = 1'b0;
    while (rises < 5 && n < 400) begin
      if (sck && !prev) rises++;
      prev = sck;
      if (rises < 5) begin
        @(negedge clk);
        n++;
      end
    end
    check("mid_rise5_reached", 32'(rises), 32'd5);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_ss", 32'(ss), 32'd1);
    check("mid_sck", 32'(sck), 32'd0);
    check("mid_mosi", 32'(mosi), 32'd0);
    check("mid_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check("mid_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("mid_rsp_rdata", 32'(bus.rsp_rdata), 32'd0);
    hi = 0;
    repeat (150) begin
      @(negedge clk);
      if (bus.rsp_valid || !ss) hi++;
    end
    check("mid_no_activity", 32'(hi), 32'd0);
    check("mid_no_frame", 32'(s_frames), 32'(frames0));
    run_txn(1'b0, 7'h01, 8'h3C, 8'h00, 0);
    ref_mem[7'h01] = 8'h3C;
    run_txn(1'b1, 7'h01, 8'h00, 8'h3C, 0);

    // ---- randomized traffic against the reference register file
    for (int i = 0; i < 16; i++) begin
      rd     = 1'($urandom_range(0, 1));
      addr   = 7'h50 + 7'($urandom_range(0, 7));
      wd     = 8'($urandom);
      exp_rd = rd ? ref_mem[addr] : 8'h00;
      run_txn(rd, addr, wd, exp_rd, 0);
      if (!rd) ref_mem[addr] = wd;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
